// File: rtl/key_entry_reader.sv
// Keypad consumer: handshakes keys from the debouncer and assembles a hex entry.
// Enter publishes the entry on value with a one-cycle commit pulse.
module key_entry_reader #(
    parameter int DIGITS      = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_ready,
    input  logic [4:0]            key_code,
    output logic                  readn,
    output logic [4*DIGITS-1:0]   entry,
    output logic [3:0]            digit_cnt,
    output logic [4*DIGITS-1:0]   value,
    output logic                  commit,
    output logic                  overflow,
    output logic                  ack_err
);
    // state    | meaning
    // IDLE     | waiting for key_ready; key is decoded on the capturing edge
    // ACK      | readn low for one cycle
    // WAIT_REL | waiting for key_ready to drop, bounded by ACK_TIMEOUT
    localparam int            CW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [3:0]    DMAX = 4'(DIGITS);
    localparam logic [CW-1:0] TMAX = CW'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_REL} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            readn     <= 1'b1;
            entry     <= '0;
            digit_cnt <= 4'd0;
            value     <= '0;
            commit    <= 1'b0;
            overflow  <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            commit <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_ready) begin
                        readn <= 1'b0;
                        state <= ACK;
                        if (!key_code[4]) begin
                            if (digit_cnt < DMAX) begin
                                entry     <= {entry[4*DIGITS-5:0], key_code[3:0]};
                                digit_cnt <= digit_cnt + 4'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            case (key_code[3:0])
                                4'h0: begin
                                    if (digit_cnt != 4'd0) begin
                                        entry     <= entry >> 4;
                                        digit_cnt <= digit_cnt - 4'd1;
                                    end
                                end
                                4'h1: begin
                                    value     <= entry;
                                    commit    <= 1'b1;
                                    entry     <= '0;
                                    digit_cnt <= 4'd0;
                                end
                                4'h2: begin
                                    entry     <= '0;
                                    digit_cnt <= 4'd0;
                                    overflow  <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ACK: begin
                    readn <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    cnt <= cnt_inc;
                    if (!key_ready) begin
                        state <= IDLE;
                    end else if (cnt_inc == TMAX) begin
                        // a stuck key_ready is then re-read as a fresh key
                        ack_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_entry_reader.sv
// Bench for key_entry_reader: debouncer model drives keys, a digit-queue model
// predicts entry/value/flags.
module tb_key_entry_reader;
    localparam int DIGITS      = 8;
    localparam int ACK_TIMEOUT = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                key_ready = 1'b0;
    logic [4:0]          key_code = 5'd0;
    logic                readn;
    logic [4*DIGITS-1:0] entry;
    logic [3:0]          digit_cnt;
    logic [4*DIGITS-1:0] value;
    logic                commit;
    logic                overflow;
    logic                ack_err;

    int checks   = 0;
    int failures = 0;

    int          m_digits[$];
    logic [63:0] m_value;
    bit          m_ovf;
    bit          m_aerr;

    key_entry_reader #(.DIGITS(DIGITS), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_ready (key_ready),
        .key_code  (key_code),
        .readn     (readn),
        .entry     (entry),
        .digit_cnt (digit_cnt),
        .value     (value),
        .commit    (commit),
        .overflow  (overflow),
        .ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] m_entry();
        logic [63:0] e = 64'd0;
        foreach (m_digits[i]) e = e * 16 + 64'(m_digits[i]);
        return e;
    endfunction

    function automatic void m_reset();
        m_digits.delete();
        m_value = 64'd0;
        m_ovf   = 1'b0;
        m_aerr  = 1'b0;
    endfunction

    // returns 1 when the key should produce a commit pulse
    function automatic bit m_apply(input int code);
        if (code < 16) begin
            if (m_digits.size() < DIGITS) m_digits.push_back(code);
            else m_ovf = 1'b1;
        end else if (code == 16) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (code == 17) begin
            m_value = m_entry();
            m_digits.delete();
            return 1'b1;
        end else if (code == 18) begin
            m_digits.delete();
            m_ovf = 1'b0;
        end
        return 1'b0;
    endfunction

    task automatic check_state(input string tag);
        check_val({tag, ".entry"},     64'(entry),     m_entry());
        check_val({tag, ".digit_cnt"}, 64'(digit_cnt), 64'(m_digits.size()));
        check_val({tag, ".value"},     64'(value),     m_value);
        check_val({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
        check_val({tag, ".ack_err"},   64'(ack_err),   64'(m_aerr));
    endtask

    // Debouncer model: raise key_ready, drop it 'drop' cycles after readn falls.
    // Called and returning at a negedge.
    task automatic press(input int code, input int drop);
        int lo   = 0;
        int com  = 0;
        int fall = -1;
        bit exp_c;
        string tag;
        tag = $sformatf("key%02h", code);
        key_ready = 1'b1;
        key_code  = 5'(code);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (readn === 1'b0) begin
                lo++;
                if (fall < 0) begin
                    fall = c;
                    key_code = 5'($urandom_range(0, 31));
                end
            end
            if (commit === 1'b1) com++;
            if (fall >= 0 && c == fall + drop) key_ready = 1'b0;
        end
        key_ready = 1'b0;
        exp_c = m_apply(code);
        check_val({tag, ".readn_pulses"},  64'(lo),  64'd1);
        check_val({tag, ".commit_pulses"}, 64'(com), 64'(exp_c));
        check_state(tag);
    endtask

    initial begin
        int lo;
        int first_err;
        int r;
        int code;

        m_reset();
        repeat (3) @(negedge clk);
        check_val("rst.readn",  64'(readn),  64'd1);
        check_val("rst.commit", 64'(commit), 64'd0);
        check_state("rst");
        rst = 1'b0;
        @(negedge clk);

        // digit entry
        press(5'h01, 2); press(5'h02, 2); press(5'h03, 2);
        check_val("t1.entry", 64'(entry), 64'h123);
        press(5'h12, 2);

        // enter commits and clears
        press(5'h0A, 2); press(5'h0B, 2); press(5'h11, 2);
        check_val("t2.value", 64'(value), 64'hAB);

        // overflow then clear
        for (int d = 1; d <= 9; d++) press(d, 2);
        check_val("t3.entry", 64'(entry), 64'h12345678);
        check_val("t3.ovf",   64'(overflow), 64'd1);
        press(5'h12, 2);

        // backspace down to empty and past it
        press(5'h05, 2); press(5'h06, 2);
        press(5'h10, 2); press(5'h10, 2); press(5'h10, 2);
        press(5'h11, 1);
        check_val("t4.empty_enter", 64'(value), 64'd0);

        // stuck key_ready: timeout, then re-capture
        key_ready = 1'b1;
        key_code  = 5'h13;
        lo = 0;
        first_err = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (readn === 1'b0) lo++;
            if (ack_err === 1'b1 && first_err < 0) first_err = c;
        end
        key_ready = 1'b0;
        repeat (4) @(negedge clk);
        check_val("t5.readn_pulses", 64'(lo), 64'd2);
        check_val("t5.err_cycle", 64'(first_err), 64'd5);
        m_aerr = 1'b1;
        check_state("t5");

        // random keys
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       code = $urandom_range(0, 15);
            else if (r == 6) code = 16;
            else if (r == 7) code = 17;
            else if (r == 8) code = 18;
            else             code = $urandom_range(19, 31);
            press(code, $urandom_range(0, 2));
        end

        // reset while in ACK, with key_ready still pending afterwards
        press(5'h04, 2);
        key_ready = 1'b1;
        key_code  = 5'h09;
        @(negedge clk);
        check_val("t6.in_ack", 64'(readn), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6.readn",  64'(readn),  64'd1);
        check_val("t6.commit", 64'(commit), 64'd0);
        m_reset();
        check_state("t6.rst");
        rst = 1'b0;
        press(5'h07, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
